e_pipe_ctrl: RTL

E_PIPE_CTRL -- requirements
Module: e_pipe_ctrl

---
 rtl/y86_pkg.sv | 42 ++++
 rtl/pipe_hazard.sv | 33 +++
 rtl/e_pipe_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 pipeline encodings: icodes, status codes, register ids and the
// control-field bundle carried by pipeline registers.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE    = 4'hF;

  localparam logic [1:0] S_AOK    = 2'd0;
  localparam logic [1:0] S_HLT    = 2'd1;
  localparam logic [1:0] S_ADR    = 2'd2;
  localparam logic [1:0] S_INS    = 2'd3;

  typedef struct packed {
    logic [1:0] stat;
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] dstE;
    logic [3:0] dstM;
    logic [3:0] srcA;
    logic [3:0] srcB;
  } ctl_t;

  function automatic ctl_t bubble_ctl();
    ctl_t c;
    c.stat  = S_AOK;
    c.icode = I_NOP;
    c.ifun  = 4'h0;
    c.dstE  = RNONE;
    c.dstM  = RNONE;
    c.srcA  = RNONE;
    c.srcB  = RNONE;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard.sv
// Combinational hazard detection for the F/D/E stages: load/use interlock,
// branch mispredict squash and ret-pending fetch stall.
module pipe_hazard
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic [3:0] M_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic       e_Cnd,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble
);

  logic load_use, mispredict, ret_pend;

  // E_dstM is never RNONE when it matches, so an RNONE source cannot interlock.
  assign load_use   = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                      (E_dstM != RNONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mispredict = (E_icode == I_JXX) && !e_Cnd;
  assign ret_pend   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);

  assign F_stall  = load_use | ret_pend;
  assign D_stall  = load_use;
  assign D_bubble = mispredict | (ret_pend & ~load_use);
  assign E_bubble = mispredict | load_use;

endmodule

// File: rtl/e_pipe_ctrl.sv
// Execute-stage pipeline register with bubble injection and a saturating
// count of injected bubbles; hazard logic lives in pipe_hazard.
module e_pipe_ctrl
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       D_stat,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       D_ifun,
  input  logic [WIDTH-1:0] D_valC,
  input  logic [WIDTH-1:0] d_valA,
  input  logic [WIDTH-1:0] d_valB,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  output logic [1:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [WIDTH-1:0] E_valC,
  output logic [WIDTH-1:0] E_valA,
  output logic [WIDTH-1:0] E_valB,
  output logic [3:0]       E_dstE,
  output logic [3:0]       E_dstM,
  output logic [3:0]       E_srcA,
  output logic [3:0]       E_srcB,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic [31:0]      bubble_cnt
);

  ctl_t d_ctl, e_ctl;

  assign d_ctl = '{stat: D_stat, icode: D_icode, ifun: D_ifun, dstE: d_dstE,
                   dstM: d_dstM, srcA: d_srcA, srcB: d_srcB};

  // E never stalls: every edge loads either the decode bundle or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ctl  <= bubble_ctl();
      E_valC <= '0;
      E_valA <= '0;
      E_valB <= '0;
    end else if (E_bubble) begin
      e_ctl  <= bubble_ctl();
      E_valC <= '0;
      E_valA <= '0;
      E_valB <= '0;
    end else begin
      e_ctl  <= d_ctl;
      E_valC <= D_valC;
      E_valA <= d_valA;
      E_valB <= d_valB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if (E_bubble && (bubble_cnt != 32'hFFFF_FFFF))
      bubble_cnt <= bubble_cnt + 32'd1;
  end

  assign E_stat  = e_ctl.stat;
  assign E_icode = e_ctl.icode;
  assign E_ifun  = e_ctl.ifun;
  assign E_dstE  = e_ctl.dstE;
  assign E_dstM  = e_ctl.dstM;
  assign E_srcA  = e_ctl.srcA;
  assign E_srcB  = e_ctl.srcB;

  pipe_hazard u_hazard (
    .D_icode  (D_icode),
    .E_icode  (e_ctl.icode),
    .E_dstM   (e_ctl.dstM),
    .M_icode  (M_icode),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .e_Cnd    (e_Cnd),
    .F_stall  (F_stall),
    .D_stall  (D_stall),
    .D_bubble (D_bubble),
    .E_bubble (E_bubble)
  );

endmodule
